ase_fifo_reader: RTL and testbench

ASE_FIFO_READER -- requirements
Module: ase_fifo_reader

---
 rtl/ase_fifo_reader_pkg.sv | 18 +
 rtl/ase_fifo_reader_stage.sv | 65 ++++++
 rtl/ase_fifo_reader.sv | 107 ++++++++++
 tb/tb_ase_fifo_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ase_fifo_reader_pkg.sv
// Shared types and constants for the ase FIFO reader and its staging buffer.
package ase_fifo_reader_pkg;

  // Number of staging entries; the stage pointers below assume exactly two.
  localparam int STAGE_DEPTH = 2;

  // Head/tail pointer into the two-entry stage; wraps modulo 2.
  typedef logic stage_ptr_t;

  // Staged-word count, 0..2.
  typedef logic [1:0] occ_t;

  // Advance a stage pointer with natural modulo-2 wrap.
  function automatic stage_ptr_t ptr_inc(input stage_ptr_t p);
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/ase_fifo_reader_stage.sv
// Two-entry staging register file with head/tail pointers and occupancy.
// Writes land at the tail; the head entry is presented first-word-fall-through.
// A write into a full stage without a simultaneous pop is dropped and leaves
// the stage untouched. A write and a pop in the same cycle keep occupancy.
module ase_fifo_reader_stage
  import ase_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output occ_t                  occupancy
);

  localparam occ_t OCC_FULL = occ_t'(STAGE_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [STAGE_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [STAGE_DEPTH];
  stage_ptr_t            head_q, head_d;
  stage_ptr_t            tail_q, tail_d;
  occ_t                  occ_q, occ_d;
  logic                  wr_ok;

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    wr_ok  = wr_en & ((occ_q != OCC_FULL) | pop);
    if (wr_ok) begin
      mem_d[tail_q] = wr_data;
      tail_d        = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end
    occ_d = occ_q + occ_t'(wr_ok) - occ_t'(pop);
  end

  // Control state: cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Storage: contents are meaningless while occupancy says empty, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[head_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/ase_fifo_reader.sv
// Reader front-end for an ase FIFO with one-cycle read latency. Issues reads
// only when the stage is guaranteed room for the returning word, and presents
// staged words downstream in first-word-fall-through form.
//
// Handshake: a downstream word transfers on a cycle with out_valid=1 and
// out_ready=1; out_valid never depends on out_ready. Upstream, a read is
// accepted when fifo_rd_en=1 and fifo_empty=0, and its data returns with
// fifo_dout_v=1 exactly one cycle later.
//
// Optional feature: define ASE_FIFO_READER_PROTOCOL_CHK_EN to build the sticky
// upstream-protocol checker; otherwise protocol_err is tied low.
module ase_fifo_reader
  import ase_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int STAGE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_dout_v,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            occupancy,
  output logic                  protocol_err
);

  localparam occ_t OCC_FULL = occ_t'(STAGE_DEPTH);

  logic       inflight_q, inflight_d;
  logic       after_rst_q, after_rst_d;
  logic       pop;
  logic       stage_wr;
  logic [2:0] credit;
  occ_t       stage_occ;

  // Issue/credit: count staged plus in-flight words, less the one leaving now.
  always_comb begin
    pop         = out_valid & out_ready;
    credit      = {1'b0, stage_occ} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en  = ~rst & ~fifo_empty & (credit < {1'b0, OCC_FULL});
    inflight_d  = fifo_rd_en;
    // Data returning in the first cycle after reset belongs to a pre-reset read.
    stage_wr    = fifo_dout_v & ~after_rst_q;
    after_rst_d = rst;
  end

  // In-flight read tracking and the post-reset marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
    after_rst_q <= after_rst_d;
  end

  ase_fifo_reader_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_stage (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (stage_wr),
    .wr_data   (fifo_dout),
    .pop       (pop),
    .head_data (out_data),
    .occupancy (stage_occ)
  );

  assign out_valid = (stage_occ != '0);
  assign occupancy = stage_occ;

`ifdef ASE_FIFO_READER_PROTOCOL_CHK_EN
  logic drop;
  logic err_event;
  logic protocol_err_q, protocol_err_d;

  // Flag unexpected data, missing data, or a data word that found the stage full.
  always_comb begin
    drop           = stage_wr & (stage_occ == OCC_FULL) & ~pop;
    err_event      = ~after_rst_q &
                     ((fifo_dout_v & ~inflight_q) | (~fifo_dout_v & inflight_q) | drop);
    protocol_err_d = protocol_err_q | err_event;
  end

  // Sticky error flag, cleared only by reset; one message per offending cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_err_q <= 1'b0;
    end else begin
      protocol_err_q <= protocol_err_d;
      if (err_event) begin
        $error("ase_fifo_reader: upstream protocol violation (dout_v=%0b inflight=%0b drop=%0b)",
               fifo_dout_v, inflight_q, drop);
      end
    end
  end

  assign protocol_err = protocol_err_q;
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_ase_fifo_reader.sv
// Bench for ase_fifo_reader: an 8-deep ase FIFO model upstream, directed
// scenarios, and a scoreboard whose monitor checks every downstream transfer.
module tb_ase_fifo_reader;

  localparam int DW = 64;
`ifdef ASE_FIFO_READER_PROTOCOL_CHK_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          fifo_dout_v;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    occupancy;
  logic          protocol_err;

  ase_fifo_reader #(.DATA_WIDTH(DW), .STAGE_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_dout    (fifo_dout),
    .fifo_dout_v  (fifo_dout_v),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .occupancy    (occupancy),
    .protocol_err (protocol_err)
  );

  // ---------------- upstream ase FIFO model (depth 8, 1-cycle read) ----------------
  logic [DW-1:0] fifo_q [$];
  logic          model_empty = 1'b1;
  logic [DW-1:0] model_dout  = '0;
  logic          model_v     = 1'b0;
  logic          force_v     = 1'b0;
  logic [DW-1:0] force_data  = '0;

  always @(posedge clk) begin
    if (fifo_rd_en && !model_empty) begin
      model_dout  <= fifo_q.pop_front();
      model_v     <= 1'b1;
      model_empty <= (fifo_q.size() == 0);
    end else begin
      model_v <= 1'b0;
    end
  end

  assign fifo_empty  = model_empty;
  assign fifo_dout_v = model_v | force_v;
  assign fifo_dout   = force_v ? force_data : model_dout;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q [$];
  int checks     = 0;
  int errors     = 0;
  int deliveries = 0;
  int issue_cnt  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every downstream transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      deliveries++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected none at %0t", out_data, $time);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
    if (fifo_rd_en === 1'b1 && fifo_empty === 1'b0) issue_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_push(input logic [DW-1:0] d, input bit expect_out);
    fifo_q.push_back(d);
    model_empty = 1'b0;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic fifo_flush();
    fifo_q.delete();
    model_empty = 1'b1;
  endtask

  task automatic do_reset();
    tick();
    rst       = 1'b1;
    out_ready = 1'b0;
    fifo_flush();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Watchdog: the scenarios are fixed-length, but never let the run hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;

    // Reset: read request held low even with a non-empty FIFO.
    tick();
    fifo_push(64'h99, 1'b0);
    @(negedge clk);
    check("rd_en_in_reset", fifo_rd_en, 0);
    tick();
    fifo_flush();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_protocol_err", protocol_err, 0);

    // Scenario 1: 0x10..0x17, out_ready=1 -> first word two cycles after issue, no gaps.
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) fifo_push(64'h10 + i, 1'b1);
    @(negedge clk);
    check("s1_issue_cycle_n", fifo_rd_en, 1);
    check("s1_valid_cycle_n", out_valid, 0);
    @(negedge clk);
    check("s1_valid_cycle_n1", out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("s1_stream_valid", out_valid, 1);
    end
    @(negedge clk);
    check("s1_drained", out_valid, 0);
    check("s1_deliveries", deliveries, 8);

    // Scenario 2: backpressure for 20 cycles -> two issues, stage full, reads stop.
    tick();
    out_ready = 1'b0;
    issue_cnt = 0;
    for (int i = 0; i < 8; i++) fifo_push(64'h10 + i, 1'b1);
    repeat (20) @(negedge clk);
    check("s2_issue_count", issue_cnt, 2);
    check("s2_occupancy_full", occupancy, 2);
    check("s2_rd_en_stalled", fifo_rd_en, 0);
    // Unsolicited word into a full stage must be dropped.
    tick();
    force_v    = 1'b1;
    force_data = 64'hEE;
    tick();
    force_v = 1'b0;
    @(negedge clk);
    check("s2_drop_occupancy", occupancy, 2);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("s2_stream_valid", out_valid, 1);
    end
    @(negedge clk);
    check("s2_drained", out_valid, 0);
    check("s2_deliveries", deliveries, 16);

    // Scenario 3: single word, out_ready toggling.
    do_reset();
    base      = deliveries;
    issue_cnt = 0;
    fifo_push(64'hAB, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      out_ready = ~out_ready;
    end
    @(negedge clk);
    check("s3_delivered_once", deliveries - base, 1);
    check("s3_valid_after", out_valid, 0);
    check("s3_single_issue", issue_cnt, 1);

    // Scenario 4: reset with one word staged and one in flight.
    do_reset();
    out_ready = 1'b0;
    fifo_push(64'h30, 1'b1);
    fifo_push(64'h31, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("s4_pre_reset_occupancy", occupancy, 1);
    check("s4_rd_en_in_reset", fifo_rd_en, 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    // Stale data valid right after reset release must be ignored.
    force_v    = 1'b1;
    force_data = 64'hCC;
    @(negedge clk);
    check("s4_post_reset_valid", out_valid, 0);
    check("s4_post_reset_occupancy", occupancy, 0);
    tick();
    force_v = 1'b0;
    @(negedge clk);
    check("s4_stale_ignored_occ", occupancy, 0);
    check("s4_stale_no_err", protocol_err, 0);
    base = deliveries;
    tick();
    out_ready = 1'b1;
    fifo_push(64'h20, 1'b1);
    repeat (6) @(negedge clk);
    check("s4_only_one_word", deliveries - base, 1);

    // Scenario 5: data valid with no read issued.
    do_reset();
    out_ready = 1'b1;
    tick();
    force_v    = 1'b1;
    force_data = 64'h5A;
    exp_q.push_back(64'h5A);
    tick();
    force_v = 1'b0;
    @(negedge clk);
    check("s5_protocol_err_set", protocol_err, EXP_PERR);
    repeat (3) @(negedge clk);
    check("s5_protocol_err_held", protocol_err, EXP_PERR);
    do_reset();
    @(negedge clk);
    check("s5_protocol_err_cleared", protocol_err, 0);

    // Everything expected must have been delivered.
    check("exp_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
